twiddle_rom_reader: RTL and testbench

TWIDDLE_ROM_READER -- requirements
Module: twiddle_rom_reader

---
 rtl/twiddle_rom_reader.sv | 187 ++++++++++++++++++
 tb/tb_twiddle_rom_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_rom_reader.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// twiddle_rom_reader
//
// Purpose:
//   Turns a stream of twiddle indices k from the twiddle address generator into
//   Q1.(DATA_WIDTH-1) twiddle factors W = cos(2*pi*k/NFFT) +/- j*sin(2*pi*k/NFFT).
//   The pipeline is two stages deep. Stage 1 registers the address and its
//   valid flag. Stage 2 reads the table, applies the sign and registers every
//   output. A count of valid outputs produces a one-cycle frame_done pulse on
//   every NFFT-th twiddle.
//
// Parameters:
//   NFFT       - FFT length (power of two, >= 8)
//   DATA_WIDTH - signed twiddle component width
//   INVERSE    - 1: exp(+j2*pi*k/NFFT) (IFFT), 0: exp(-j2*pi*k/NFFT) (FFT)
//
// Ports:
//   clk             - single clock, all state on the rising edge
//   rst             - asynchronous active-high reset
//   Twiddle_active  - address-valid qualifier
//   Twiddle_address - twiddle index k, log2(NFFT/2) bits
//   W_real          - cosine component (signed), 0 when W_valid = 0
//   W_imag          - signed sine component, 0 when W_valid = 0
//   W_valid         - Twiddle_active delayed by two cycles
//   frame_done      - pulses together with the NFFT-th valid twiddle
//
// Configuration macro:
//   TWIDDLE_QUARTER_ROM_EN - when defined, only NFFT/4+1 cosine entries are
//   stored and the index is folded. The outputs are bit-identical to the full
//   cos/sin tables used otherwise.
// ----------------------------------------------------------------------------
module twiddle_rom_reader #(
    parameter int NFFT       = 128,
    parameter int DATA_WIDTH = 16,
    parameter bit INVERSE    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Twiddle_active,
    input  logic [$clog2(NFFT/2)-1:0]     Twiddle_address,
    output logic [DATA_WIDTH-1:0]         W_real,
    output logic [DATA_WIDTH-1:0]         W_imag,
    output logic                          W_valid,
    output logic                          frame_done
);

    localparam int  AW    = $clog2(NFFT / 2);
    localparam int  CW    = $clog2(NFFT);
    localparam int  S_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;
    localparam logic [CW-1:0] CNT_LAST = CW'(NFFT - 1);

    // Scale a real value in [-1, 1] by S_MAX and round half away from zero.
    function automatic logic [DATA_WIDTH-1:0] to_fixed(input real v);
        real scaled;
        int  r;
        scaled = v * real'(S_MAX);
        if (scaled >= 0.0) begin
            r = $rtoi(scaled + 0.5);
        end else begin
            r = -$rtoi(0.5 - scaled);
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    // Two's-complement negation that clamps the most negative code to +max.
    function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] v);
        if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return -v;
    endfunction

    logic                  act_q, act_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] w_real_q, w_real_d;
    logic [DATA_WIDTH-1:0] w_imag_q, w_imag_d;
    logic                  w_valid_q, w_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] cos_val;
    logic [DATA_WIDTH-1:0] sin_val;

`ifdef TWIDDLE_QUARTER_ROM_EN
    localparam int            QUARTER     = NFFT / 4;
    localparam logic [AW-1:0] QUARTER_IDX = AW'(QUARTER);

    // C[m] = cos(2*pi*m/NFFT) for m = 0..NFFT/4. All entries are non-negative.
    logic [DATA_WIDTH-1:0] cos_rom [0:QUARTER];

    for (genvar m = 0; m <= QUARTER; m++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] C_VAL =
            to_fixed($cos(2.0 * PI * real'(m) / real'(NFFT)));
        assign cos_rom[m] = C_VAL;
    end

    logic [AW-1:0] low_idx;
    logic [AW-1:0] mirror_idx;

    // The address MSB selects the quadrant (k >= NFFT/4). low_idx is k within
    // that quadrant and mirror_idx is its reflection NFFT/4 - low_idx, so:
    //   first quadrant:  cos = C[k],         sin = C[NFFT/4-k]
    //   second quadrant: cos = -C[NFFT/4-m], sin = C[m]
    always_comb begin
        low_idx    = {1'b0, addr_q[AW-2:0]};
        mirror_idx = QUARTER_IDX - low_idx;
        cos_val    = '0;
        sin_val    = '0;
        if (!addr_q[AW-1]) begin
            cos_val = cos_rom[low_idx];
            sin_val = cos_rom[mirror_idx];
        end else begin
            cos_val = neg_sat(cos_rom[mirror_idx]);
            sin_val = cos_rom[low_idx];
        end
    end
`else
    // Full half-period tables indexed directly by k.
    logic [DATA_WIDTH-1:0] cos_rom [0:(NFFT/2)-1];
    logic [DATA_WIDTH-1:0] sin_rom [0:(NFFT/2)-1];

    for (genvar k = 0; k < NFFT / 2; k++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] C_VAL =
            to_fixed($cos(2.0 * PI * real'(k) / real'(NFFT)));
        localparam logic [DATA_WIDTH-1:0] S_VAL =
            to_fixed($sin(2.0 * PI * real'(k) / real'(NFFT)));
        assign cos_rom[k] = C_VAL;
        assign sin_rom[k] = S_VAL;
    end

    // Direct lookup of both components.
    always_comb begin
        cos_val = cos_rom[addr_q];
        sin_val = sin_rom[addr_q];
    end
`endif

    // Next-state logic for both pipeline stages and the frame counter.
    // The address register only loads when the qualifier is high, because the
    // address is meaningless otherwise. The counter tracks valid outputs, so
    // frame_done is raised when the sample that wraps the counter is issued.
    always_comb begin
        act_d        = Twiddle_active;
        addr_d       = Twiddle_active ? Twiddle_address : addr_q;
        w_valid_d    = act_q;
        w_real_d     = '0;
        w_imag_d     = '0;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        if (act_q) begin
            w_real_d     = cos_val;
            w_imag_d     = INVERSE ? sin_val : neg_sat(sin_val);
            cnt_d        = cnt_q + 1'b1;
            frame_done_d = (cnt_q == CNT_LAST);
        end
    end

    // All state is held here. Reset clears the in-flight samples and the
    // counter, which drops any address that was accepted before reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= 1'b0;
            addr_q       <= '0;
            w_real_q     <= '0;
            w_imag_q     <= '0;
            w_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            act_q        <= act_d;
            addr_q       <= addr_d;
            w_real_q     <= w_real_d;
            w_imag_q     <= w_imag_d;
            w_valid_q    <= w_valid_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign W_real     = w_real_q;
    assign W_imag     = w_imag_q;
    assign W_valid    = w_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_twiddle_rom_reader.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_twiddle_rom_reader
//
// Drives one shared input stream into two instances of twiddle_rom_reader.
// One instance is built as an IFFT reader (INVERSE=1) and the other as an FFT
// reader (INVERSE=0). Every cycle, each output is compared with a reference
// that computes the twiddle directly from cos/sin with round-half-away, takes
// the sample from the stream two cycles earlier, and counts frames as the
// running number of valid outputs modulo NFFT.
// ----------------------------------------------------------------------------
module tb_twiddle_rom_reader;

    localparam int  NFFT = 128;
    localparam int  DW   = 16;
    localparam int  AW   = 6;
    localparam int  S    = 32767;
    localparam real PI   = 3.14159265358979323846;

    typedef struct {
        bit act;
        int k;
    } step_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          Twiddle_active;
    logic [AW-1:0] Twiddle_address;
    logic [DW-1:0] W_real, W_imag;
    logic          W_valid, frame_done;
    logic [DW-1:0] fwd_real, fwd_imag;
    logic          fwd_valid, fwd_done;

    step_t hist[$];
    int    checks     = 0;
    int    errors     = 0;
    int    validCount = 0;
    int    fdSeen     = 0;

    twiddle_rom_reader #(.NFFT(NFFT), .DATA_WIDTH(DW), .INVERSE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .Twiddle_active(Twiddle_active), .Twiddle_address(Twiddle_address),
        .W_real(W_real), .W_imag(W_imag), .W_valid(W_valid), .frame_done(frame_done)
    );

    twiddle_rom_reader #(.NFFT(NFFT), .DATA_WIDTH(DW), .INVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst(rst),
        .Twiddle_active(Twiddle_active), .Twiddle_address(Twiddle_address),
        .W_real(fwd_real), .W_imag(fwd_imag), .W_valid(fwd_valid), .frame_done(fwd_done)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Stop the run if the stimulus never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int roundAway(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int refCos(input int k);
        return roundAway($cos(2.0 * PI * real'(k) / real'(NFFT)) * real'(S));
    endfunction

    function automatic int refSin(input int k);
        return roundAway($sin(2.0 * PI * real'(k) / real'(NFFT)) * real'(S));
    endfunction

    // One comparison, counted and reported as an assertion failure.
    task automatic checkVal(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every output with the reference for the sample driven two steps earlier.
    task automatic checkOutput();
        step_t e;
        int    er, ei;
        bit    efd;
        e.act = 1'b0;
        e.k   = 0;
        if (hist.size() >= 2) e = hist[hist.size() - 2];
        er  = 0;
        ei  = 0;
        efd = 1'b0;
        if (e.act) begin
            validCount++;
            er  = refCos(e.k);
            ei  = refSin(e.k);
            efd = (validCount % NFFT) == 0;
        end
        checkVal("W_valid",    {31'b0, W_valid},    {31'b0, e.act});
        checkVal("W_real",     $signed(W_real),     er);
        checkVal("W_imag",     $signed(W_imag),     ei);
        checkVal("frame_done", {31'b0, frame_done}, {31'b0, efd});
        checkVal("fwd_real",   $signed(fwd_real),   er);
        checkVal("fwd_imag",   $signed(fwd_imag),   -ei);
        if (frame_done === 1'b1) fdSeen++;
    endtask

    // Advance one clock cycle, check the outputs, then drive the next input.
    task automatic applyStimulus(input bit act, input int k);
        step_t s;
        @(posedge clk);
        #1;
        checkOutput();
        Twiddle_active  = act;
        Twiddle_address = act ? AW'(k) : AW'($urandom);
        s.act = act;
        s.k   = k;
        hist.push_back(s);
    endtask

    // Assert reset for one cycle. The outputs must clear right away, without a clock edge.
    task automatic resetPulse();
        rst            = 1'b1;
        Twiddle_active = 1'b0;
        #1;
        checkVal("rst_W_valid",    {31'b0, W_valid},    0);
        checkVal("rst_W_real",     $signed(W_real),     0);
        checkVal("rst_W_imag",     $signed(W_imag),     0);
        checkVal("rst_frame_done", {31'b0, frame_done}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        hist.delete();
        validCount = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
    endtask

    initial begin
        int kvec [0:5];
        int litR [0:3];
        int litI [0:3];
        int issued;

        kvec = '{0, 16, 32, 48, 0, 0};
        litR = '{32767, 23170, 0, -23170};
        litI = '{0, 23170, 32767, 23170};

        rst             = 1'b1;
        Twiddle_active  = 1'b0;
        Twiddle_address = '0;
        @(posedge clk);
        #1;
        checkOutput();
        @(posedge clk);
        #2;
        rst = 1'b0;

        $display("[TB] directed quarter-point twiddles");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 4, kvec[i]);
            if (i >= 2) begin
                checkVal("lit_W_valid", {31'b0, W_valid}, 1);
                checkVal("lit_W_real",  $signed(W_real),  litR[i-2]);
                checkVal("lit_W_imag",  $signed(W_imag),  litI[i-2]);
            end
            if (i == 4) begin
                checkVal("fwd_k32_real", $signed(fwd_real), 0);
                checkVal("fwd_k32_imag", $signed(fwd_imag), -32767);
            end
        end
        drain();
        resetPulse();

        $display("[TB] one frame with random gaps");
        fdSeen = 0;
        issued = 0;
        while (issued < NFFT) begin
            if ($urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 0);
            end else begin
                applyStimulus(1'b1, int'($urandom_range(0, 63)));
                issued++;
            end
        end
        drain();
        checkVal("frame_done_count_gaps", fdSeen, 1);

        $display("[TB] reset with addresses in flight, then full sweep");
        applyStimulus(1'b1, 5);
        applyStimulus(1'b1, 9);
        resetPulse();
        fdSeen = 0;
        applyStimulus(1'b0, 0);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 64; k++) applyStimulus(1'b1, k);
        end
        drain();
        checkVal("frame_done_count_after_reset", fdSeen, 1);

        $display("[TB] continuous 256 valid twiddles");
        fdSeen = 0;
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, int'($urandom_range(0, 63)));
        drain();
        checkVal("frame_done_count_continuous", fdSeen, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
